// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int NUM_LINES_DEF   = 8;
  localparam int BLOCK_BYTES_DEF = 4;
  localparam int ADDR_W_DEF      = 8;

  localparam int OFFSET_W = $clog2(BLOCK_BYTES_DEF);
  localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W    = ADDR_W_DEF - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  // Single write port of the line array: CPU byte store, refill byte, or last refill byte.
  typedef enum logic [1:0] {
    WR_NONE      = 2'd0,
    WR_BYTE      = 2'd1,
    WR_FILL      = 2'd2,
    WR_FILL_LAST = 2'd3
  } wr_op_t;

  function automatic int unsigned addr_field(input int unsigned addr, input int lsb,
                                             input int width);
    int unsigned mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic int unsigned addr_offset(input int unsigned addr, input int off_w);
    return addr_field(addr, 0, off_w);
  endfunction

  function automatic int unsigned addr_index(input int unsigned addr, input int off_w,
                                             input int idx_w);
    return addr_field(addr, off_w, idx_w);
  endfunction

  function automatic int unsigned addr_tag(input int unsigned addr, input int off_w,
                                           input int idx_w, input int tag_w);
    return addr_field(addr, off_w + idx_w, tag_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read of one line, one synchronous write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [INDEX_BITS-1:0]                index,
  input  logic [OFFSET_BITS-1:0]               offset,
  input  wr_op_t                               wr_op,
  input  logic [TAG_BITS-1:0]                  wr_tag,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic [TAG_BITS-1:0]                  rd_tag,
  output logic                                 rd_valid,
  output logic                                 rd_dirty,
  output logic [BLOCK_BYTES-1:0][DATA_W-1:0]   rd_line
);

  logic [TAG_BITS-1:0] tag_q   [NUM_LINES];
  logic [DATA_W-1:0]   data_q  [NUM_LINES][BLOCK_BYTES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_tag   = tag_q[index];
  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];

  always_comb begin
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      rd_line[b] = data_q[index][b];
    end
  end

  // Only the line status is cleared by reset; tags and data keep stale contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (wr_op)
        WR_BYTE: dirty_q[index] <= 1'b1;
        WR_FILL_LAST: begin
          valid_q[index] <= 1'b1;
          dirty_q[index] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_op != WR_NONE) begin
      data_q[index][offset] <= wr_data;
    end
    if (wr_op == WR_FILL_LAST) begin
      tag_q[index] <= wr_tag;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache: hit compare, miss FSM and
// byte-serial write-back/refill towards data_mem.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = TAG_W + INDEX_W + OFFSET_W,
  parameter int DATA_W      = 8,
  parameter int NUM_LINES   = 1 << INDEX_W,
  parameter int BLOCK_BYTES = 1 << OFFSET_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_busy_wait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_busy_wait
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TG_W  = ADDR_W - IDX_W - OFF_W;

  state_t                            state;
  logic [OFF_W-1:0]                  cnt;
  logic [OFF_W-1:0]                  cnt_nxt;
  logic                              cnt_last;

  logic [TG_W-1:0]                   req_tag;
  logic [IDX_W-1:0]                  req_index;
  logic [OFF_W-1:0]                  req_offset;
  logic                              req_valid;
  logic                              req_rd;
  logic                              req_wr;

  logic [TG_W-1:0]                   line_tag;
  logic                              line_valid;
  logic                              line_dirty;
  logic [BLOCK_BYTES-1:0][DATA_W-1:0] line_data;

  logic                              hit;
  logic                              miss;
  logic                              accept;

  wr_op_t                            wr_op;
  logic [OFF_W-1:0]                  wr_offset;
  logic [DATA_W-1:0]                 wr_data;

  assign req_offset = OFF_W'(addr_offset(32'(cpu_address), OFF_W));
  assign req_index  = IDX_W'(addr_index(32'(cpu_address), OFF_W, IDX_W));
  assign req_tag    = TG_W'(addr_tag(32'(cpu_address), OFF_W, IDX_W, TG_W));

  // Both strobes high is treated like neither: no request at all.
  assign req_valid = cpu_read ^ cpu_write;
  assign req_rd    = cpu_read & ~cpu_write;
  assign req_wr    = cpu_write & ~cpu_read;

  assign hit      = line_valid && (line_tag == req_tag);
  assign miss     = req_valid && !hit;
  assign accept   = (mem_read || mem_write) && !mem_busy_wait;
  assign cnt_nxt  = cnt + OFF_W'(1);
  assign cnt_last = (cnt == OFF_W'(BLOCK_BYTES - 1));

  assign cpu_busy_wait = reset && ((state != IDLE) || miss);
  assign cpu_read_data = (reset && state == IDLE && req_rd && hit) ? line_data[req_offset]
                                                                   : '0;

  always_comb begin
    wr_op     = WR_NONE;
    wr_offset = req_offset;
    wr_data   = cpu_write_data;
    if (state == IDLE && req_wr && hit) begin
      wr_op = WR_BYTE;
    end else if (state == FETCH && accept) begin
      wr_op     = cnt_last ? WR_FILL_LAST : WR_FILL;
      wr_offset = cnt;
      wr_data   = mem_read_data;
    end
  end

  dcache_array #(
    .DATA_W      (DATA_W),
    .NUM_LINES   (NUM_LINES),
    .BLOCK_BYTES (BLOCK_BYTES),
    .INDEX_BITS  (IDX_W),
    .OFFSET_BITS (OFF_W),
    .TAG_BITS    (TG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .index    (req_index),
    .offset   (wr_offset),
    .wr_op    (wr_op),
    .wr_tag   (req_tag),
    .wr_data  (wr_data),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_line  (line_data)
  );

  // Memory-side outputs are registered and only advance when memory accepts a byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            cnt <= '0;
            if (line_valid && line_dirty) begin
              state          <= WRITEBACK;
              mem_write      <= 1'b1;
              mem_address    <= {line_tag, req_index, {OFF_W{1'b0}}};
              mem_write_data <= line_data[0];
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {req_tag, req_index, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (accept) begin
            cnt <= cnt_nxt;
            if (cnt_last) begin
              state          <= FETCH;
              mem_write      <= 1'b0;
              mem_write_data <= '0;
              mem_read       <= 1'b1;
              mem_address    <= {req_tag, req_index, {OFF_W{1'b0}}};
            end else begin
              mem_address    <= {line_tag, req_index, cnt_nxt};
              mem_write_data <= line_data[cnt_nxt];
            end
          end
        end
        FETCH: begin
          if (accept) begin
            cnt <= cnt_nxt;
            if (cnt_last) begin
              state       <= IDLE;
              mem_read    <= 1'b0;
              mem_address <= '0;
            end else begin
              mem_address <= {req_tag, req_index, cnt_nxt};
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: scoreboard of expected memory transactions plus a
// CPU-visible reference memory for load data.
module tb_dcache;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_read;
  logic       cpu_write;
  logic [7:0] cpu_address;
  logic [7:0] cpu_write_data;
  logic [7:0] cpu_read_data;
  logic       cpu_busy_wait;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;
  logic       mem_busy_wait;

  always #5 clk = ~clk;

  dcache u_dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_busy_wait  (cpu_busy_wait),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_busy_wait  (mem_busy_wait)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } mem_op_t;

  mem_op_t    exp_q[$];
  logic [7:0] mem    [256];
  logic [7:0] golden [256];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         stall_cfg = 0;
  int         wait_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [7:0] a);
    mem_op_t op;
    op.wr = 1'b0; op.addr = a; op.data = 8'h00;
    exp_q.push_back(op);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    mem_op_t op;
    op.wr = 1'b1; op.addr = a; op.data = d;
    exp_q.push_back(op);
  endtask

  // Memory model: decides stall/accept for the coming rising edge.
  task automatic mem_service();
    if (mem_read || mem_write) begin
      check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      check("mem_op_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("mem_kind", 32'(mem_write), 32'(exp_q[0].wr));
        check("mem_addr", 32'(mem_address), 32'(exp_q[0].addr));
        if (exp_q[0].wr) check("mem_wdata", 32'(mem_write_data), 32'(exp_q[0].data));
      end
      if (wait_cnt < stall_cfg) begin
        mem_busy_wait = 1'b1;
        wait_cnt++;
      end else begin
        mem_busy_wait = 1'b0;
        wait_cnt = 0;
        if (mem_write) mem[mem_address] = mem_write_data;
        else mem_read_data = mem[mem_address];
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end else begin
      mem_busy_wait = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_service();
  endtask

  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [7:0] addr, input logic [7:0] wd,
                           input int exp_busy, input logic chk_data);
    int busy_n;
    busy_n = 0;
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_write_data = wd;
    tick();
    while (cpu_busy_wait === 1'b1 && busy_n < 200) begin
      busy_n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    if (chk_data) check({tag, "_rdata"}, 32'(cpu_read_data), 32'(golden[addr]));
    if (wr && !rd) golden[addr] = wd;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 8'h00; cpu_write_data = 8'h00;
    mem_read_data = 8'h00; mem_busy_wait = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h24] = 8'h11; mem[8'h25] = 8'h22; mem[8'h26] = 8'h33; mem[8'h27] = 8'h44;
    for (int i = 0; i < 256; i++) golden[i] = mem[i];

    // Reset state
    @(posedge clk); #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
    check("rst_busy", 32'(cpu_busy_wait), 32'd0);
    check("rst_rdata", 32'(cpu_read_data), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Cold clean miss, then hit on the refilled line
    for (int i = 0; i < 4; i++) push_rd(8'h24 + 8'(i));
    do_access("cold_rd24", 1'b1, 1'b0, 8'h24, 8'h00, 5, 1'b1);
    check("cold_rd24_value", 32'(golden[8'h24]), 32'h11);
    do_access("hit_rd26", 1'b1, 1'b0, 8'h26, 8'h00, 0, 1'b1);

    // Write hit dirties the line; conflicting read writes it back then refills
    do_access("hit_wr25", 1'b0, 1'b1, 8'h25, 8'hAB, 0, 1'b0);
    push_wr(8'h24, 8'h11); push_wr(8'h25, 8'hAB); push_wr(8'h26, 8'h33); push_wr(8'h27, 8'h44);
    for (int i = 0; i < 4; i++) push_rd(8'h44 + 8'(i));
    do_access("dirty_rd45", 1'b1, 1'b0, 8'h45, 8'h00, 9, 1'b1);
    check("wb_mem25", 32'(mem[8'h25]), 32'hAB);

    // Stalling memory: 3 busy cycles per byte on a clean miss
    stall_cfg = 3;
    for (int i = 0; i < 4; i++) push_rd(8'h84 + 8'(i));
    do_access("stall_rd86", 1'b1, 1'b0, 8'h86, 8'h00, 17, 1'b1);
    stall_cfg = 0;

    // Write miss allocates, store merges into the refilled block
    for (int i = 0; i < 4; i++) push_rd(8'h5C + 8'(i));
    do_access("miss_wr5d", 1'b0, 1'b1, 8'h5D, 8'h77, 5, 1'b0);
    do_access("hit_rd5d", 1'b1, 1'b0, 8'h5D, 8'h00, 0, 1'b1);
    do_access("hit_rd5c", 1'b1, 1'b0, 8'h5C, 8'h00, 0, 1'b1);

    // Both strobes high is a no-op: no traffic, no data change, line stays clean
    for (int i = 0; i < 4; i++) push_rd(8'h10 + 8'(i));
    do_access("cold_rd10", 1'b1, 1'b0, 8'h10, 8'h00, 5, 1'b1);
    do_access("noop_10", 1'b1, 1'b1, 8'h10, 8'hEE, 0, 1'b0);
    do_access("after_noop_rd10", 1'b1, 1'b0, 8'h10, 8'h00, 0, 1'b1);
    for (int i = 0; i < 4; i++) push_rd(8'h30 + 8'(i));
    do_access("clean_evict_rd30", 1'b1, 1'b0, 8'h30, 8'h00, 5, 1'b1);

    // Reset during the second refill byte
    push_rd(8'h08);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 8'h08;
    tick();
    @(posedge clk);
    tick();
    @(posedge clk); #1;
    check("pre_abort_addr", 32'(mem_address), 32'h09);
    reset = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_mem_address", 32'(mem_address), 32'd0);
    check("abort_mem_wdata", 32'(mem_write_data), 32'd0);
    check("abort_busy", 32'(cpu_busy_wait), 32'd0);
    check("abort_rdata", 32'(cpu_read_data), 32'd0);
    cpu_read = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) push_rd(8'h08 + 8'(i));
    do_access("refetch_rd08", 1'b1, 1'b0, 8'h08, 8'h00, 5, 1'b1);

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
